// File: rtl/dmem_responder.sv
// dmem_responder: single-port data-memory responder for a pipeline memory stage.
// Accepts one load/store at a time. Each access stays BUSY for LATENCY cycles
// and a load then spends one RESP cycle that pulses memu_valid.
// Optional feature macro: MEMU_MISALIGN_CHECK_EN. When it is defined, an access
// whose shifted mask runs past bit 31 is suppressed and sets memu_misaligned.
// When it is undefined, shifted-out bits are dropped and the flag is tied 0.
module dmem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memu_cmd_start,
    input  logic        memu_cmd_write,
    input  logic [31:0] memu_addr,
    input  logic [31:0] memu_wdata,
    input  logic [31:0] memu_wmask,
    output logic        memu_cmd_ready,
    output logic        memu_valid,
    output logic [31:0] memu_rdata,
    output logic        memu_misaligned
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH+1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             wmask_q, wmask_d;
    logic                    write_q, write_d;
    logic                    ready_q, ready_d;
    logic                    valid_q, valid_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    mis_q, mis_d;

    logic [31:0]             mem [0:(1<<ADDR_WIDTH)-1];

    logic [ADDR_WIDTH-1:0]   idx_s;
    logic [4:0]              sh_s;
    logic [31:0]             mask_sh_s;
    logic [31:0]             wdata_sh_s;
    logic [31:0]             word_s;
    logic [31:0]             new_word_s;
    logic                    exec_s;
    logic                    mis_s;
    logic                    mem_we_s;
    logic                    unused_addr_s;

    // Address bits above the array are deliberately ignored so accesses wrap.
    assign unused_addr_s = ^memu_addr[31:ADDR_WIDTH+2];

`ifdef MEMU_MISALIGN_CHECK_EN
    logic [63:0] mask_wide_s;
`endif

    // Datapath: word index, lane shift, merged store word and misalignment test.
    always_comb begin
        idx_s      = addr_q[ADDR_WIDTH+1:2];
        sh_s       = {addr_q[1:0], 3'b000};
        word_s     = mem[idx_s];
        wdata_sh_s = wdata_q << sh_s;
`ifdef MEMU_MISALIGN_CHECK_EN
        mask_wide_s = {32'h0000_0000, wmask_q} << sh_s;
        mask_sh_s   = mask_wide_s[31:0];
        mis_s       = |mask_wide_s[63:32];
`else
        mask_sh_s   = wmask_q << sh_s;
        mis_s       = 1'b0;
`endif
        new_word_s = (word_s & ~mask_sh_s) | (wdata_sh_s & mask_sh_s);
        exec_s     = (state_q == BUSY) && (cnt_q == 4'd0);
        mem_we_s   = exec_s && write_q && !mis_s;
    end

    // Next-state and next-output logic for the IDLE/BUSY/RESP sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        write_d = write_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (memu_cmd_start) begin
                    addr_d  = memu_addr[ADDR_WIDTH+1:0];
                    wdata_d = memu_wdata;
                    wmask_d = memu_wmask;
                    write_d = memu_cmd_write;
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    if (write_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RESP;
                        rdata_d = mis_s ? 32'h0000_0000 : (word_s >> sh_s);
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        ready_d = (state_d == IDLE);
        valid_d = (state_d == RESP);
        mis_d   = mis_q | (exec_s & mis_s);
    end

    // Sequencer state and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0000_0000;
            wmask_q <= 32'h0000_0000;
            write_q <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            rdata_q <= 32'h0000_0000;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            write_q <= write_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
        end
    end

    // Storage array; intentionally not reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[idx_s] <= new_word_s;
        end
    end

    assign memu_cmd_ready = ready_q;
    assign memu_valid     = valid_q;
    assign memu_rdata     = rdata_q;
`ifdef MEMU_MISALIGN_CHECK_EN
    assign memu_misaligned = mis_q;
`else
    assign memu_misaligned = 1'b0;
`endif

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 12, giving the log2 of the word depth of the internal array (4096 x 32-bit words).
REQ-002 The module SHALL have parameter LATENCY, default 2, giving the BUSY cycles per access; legal range 1..15.
REQ-003 The module SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 The module SHALL have port memu_cmd_start  input  1  request strobe from the memory stage.
REQ-006 The module SHALL have port memu_cmd_write  input  1  1 = store, 0 = load.
REQ-007 The module SHALL have port memu_addr  input  32  byte address.
REQ-008 The module SHALL have port memu_wdata  input  32  store data, right-aligned.
REQ-009 The module SHALL have port memu_wmask  input  32  store bit mask, right-aligned: 0x000000ff, 0x0000ffff or 0xffffffff.
REQ-010 The module SHALL have port memu_cmd_ready  output  1  responder can accept a command this cycle.
REQ-011 The module SHALL have port memu_valid  output  1  one-cycle read-data pulse.
REQ-012 The module SHALL have port memu_rdata  output  32  load data, right-shifted by byte offset.
REQ-013 The module SHALL have port memu_misaligned  output  1  sticky misalignment flag (see Configuration).

Function
REQ-014 The FSM SHALL have states IDLE, BUSY and RESP.
REQ-015 memu_cmd_ready SHALL be 1 only in IDLE.
REQ-016 A command SHALL be accepted at a rising edge when memu_cmd_start=1 and memu_cmd_ready=1; addr, wdata, wmask and write SHALL be latched, the latency counter SHALL load LATENCY-1, and the state SHALL go to BUSY.
REQ-017 memu_cmd_start SHALL be ignored outside IDLE; no queueing.
REQ-018 BUSY SHALL decrement the counter each cycle; at count 0 the access SHALL execute on that edge.
REQ-019 A store SHALL then return to IDLE, so ready re-asserts LATENCY+1 cycles after acceptance.
REQ-020 A load SHALL then go to RESP.
REQ-021 RESP SHALL assert memu_valid for exactly one cycle and then return to IDLE.
REQ-022 Word index SHALL be addr[ADDR_WIDTH+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo the array size. Byte offset SHALL be addr[1:0].
REQ-023 A store SHALL write (wdata<<8*off) under (wmask<<8*off), truncated to 32 bits; unmasked bits SHALL be unchanged.
REQ-024 A load SHALL produce memu_rdata = word>>8*off with zero fill.
REQ-025 memu_rdata SHALL be registered and hold its value from RESP until the next load response; stores SHALL NOT change it.
REQ-026 The responder SHALL always complete an accepted command; requester flush or withdrawal SHALL have no effect.
REQ-027 An AMO load-then-store pair SHALL be two independent commands; RESP->IDLE->accept is legal back-to-back with no idle gap beyond the RESP cycle.

Reset
REQ-028 While rst_n=0: state=IDLE, counter=0, memu_cmd_ready=1, memu_valid=0, memu_rdata=0, memu_misaligned=0.
REQ-029 Reset asserted mid-access SHALL abort the access with no array write; array contents SHALL NOT be reset.
REQ-030 After reset release, a command SHALL be acceptable on the first rising edge.

Configuration
REQ-031 With MEMU_MISALIGN_CHECK_EN defined: an access whose shifted mask exceeds 32 bits (halfword at off=3, word at off!=0) SHALL still take full latency, SHALL suppress the store write, SHALL return rdata=0 for a load, and SHALL set memu_misaligned until reset.
REQ-032 Without MEMU_MISALIGN_CHECK_EN: no check; bits shifted past bit 31 SHALL be dropped; memu_misaligned SHALL be tied 0.

Verification
REQ-033 Reset, then store addr=0x10, wdata=0xdeadbeef, mask=0xffffffff; load 0x10 -> memu_valid pulses 1 cycle, 3 cycles after load acceptance (LATENCY=2), rdata=0xdeadbeef.
REQ-034 Store byte 0x55 to 0x13 over 0xdeadbeef -> load 0x10 returns 0x55adbeef; load 0x12 returns 0x000055ad.
REQ-035 Assert memu_cmd_start continuously while BUSY/RESP -> exactly one acceptance per ready window; no extra valid pulses.
REQ-036 Drop rst_n during BUSY of a store to 0x20 -> ready=1, valid=0 immediately; later load 0x20 returns the old value.
REQ-037 With MEMU_MISALIGN_CHECK_EN: word store to 0x21 -> memory unchanged, memu_misaligned=1; without the macro -> low 3 bytes written at offset 1, flag stays 0.
REQ-038 Load 0x4010 with ADDR_WIDTH=12 -> returns the word stored at 0x0010 (address wrap).
